sonar_echo_emulator: RTL and testbench
======================================

Name: sonar_echo_emulator

Overview:
Emulates an HC-SR04-style ultrasonic sensor. It watches the trigger line driven by the sonar interface and answers each valid trigger with an echo pulse whose width is set programmatically. It sits in the FPGA test build in place of the physical sensor, for hardware-in-loop checks of the ranging path. All timing is in clk cycles; the nominal clk is 50 MHz.

Parameters:
MIN_TRIG_CYCLES, 500, minimum qualified trigger high width (10 us).
BURST_CYCLES, 10000, delay from trigger acceptance to echo rise (200 us, 8-cycle 40 kHz burst).
MAX_ECHO_CYCLES, 1900000, echo width cap and no-object timeout pulse (38 ms).
HOLDOFF_CYCLES, 500000, dead time after echo fall during which triggers are ignored (10 ms).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-low (asserted when 0)
trigger  in  1  trigger from the sonar interface; asynchronous to clk
echo_width  in  32  requested echo width in cycles; 0 means no object
echo  out  1  emulated echo line, registered
busy  out  1  high in any state other than IDLE
trig_err  out  1  one-cycle pulse when a trigger is rejected as too short
trig_ignored  out  1  one-cycle pulse on a trigger rising edge seen during BURST, ECHO or HOLDOFF
pulse_count  out  16  number of echo pulses completed; wraps at 65535 -> 0

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; echo=0, busy=0, trig_err=0, trig_ignored=0, pulse_count=0; all counters and synchronizer flops cleared.
- trigger passes through a 2-flop synchronizer, giving trig_s. Edge detection compares trig_s against its previous value, so all timing below refers to trig_s, which lags the pin by 2 cycles.
- IDLE: on a trig_s rising edge -> TRIG_HIGH with tcnt=1. If trig_s is already high on entry to IDLE, no transfer happens until the next rising edge.
- TRIG_HIGH:
  - tcnt increments on every cycle trig_s=1 and saturates at MIN_TRIG_CYCLES.
  - On the first cycle trig_s=0 with tcnt>=MIN_TRIG_CYCLES: W is latched as echo_width (capped at MAX_ECHO_CYCLES); if echo_width=0, W=MAX_ECHO_CYCLES. Then -> BURST.
  - On the first cycle trig_s=0 with tcnt<MIN_TRIG_CYCLES: trig_err=1 for 1 cycle, then -> IDLE.
- BURST: stays exactly BURST_CYCLES cycles, then -> ECHO. echo=0 throughout.
- ECHO: echo=1 for exactly W consecutive cycles. On exit, echo returns to 0, pulse_count increments, and the state -> HOLDOFF.
- HOLDOFF: stays exactly HOLDOFF_CYCLES cycles, then -> IDLE.
- A trig_s rising edge in BURST, ECHO or HOLDOFF produces trig_ignored=1 for 1 cycle. The current operation is unaffected.
- echo_width is sampled only at the acceptance cycle. Changes during BURST or ECHO have no effect.
- Latency: echo rises BURST_CYCLES+1 cycles after the acceptance cycle (the trig_s fall sample).
- Counters are 32-bit unsigned, with no overflow possible given the caps.
- busy is registered and tracks state != IDLE.
- If reset is asserted mid-ECHO, echo drops to 0 immediately (asynchronously) and pulse_count clears.

Test Plan (all scenarios use MIN_TRIG=5, BURST=8, MAX_ECHO=100, HOLDOFF=20):
1. trigger high 10 cycles, echo_width=37 -> echo rises 9 cycles after the trig_s fall, stays high exactly 37 cycles; pulse_count 0->1; busy low again 20 cycles after echo falls.
2. trigger high 3 cycles -> trig_err single pulse; echo stays 0; pulse_count unchanged; busy returns low.
3. echo_width=0, then echo_width=500 on a second trigger -> echo width 100 both times; pulse_count=2.
4. Second trigger pulse (10 cycles) during ECHO and again during HOLDOFF -> trig_ignored pulses twice; only one echo pulse; a trigger after HOLDOFF yields a normal echo.
5. Reset asserted at cycle 15 of a 37-cycle echo -> echo=0 and pulse_count=0 immediately; after release, a trigger held high across release does not start a measurement; the next clean trigger does.
6. Issue 65536 minimal cycles (force pulse_count to 65535 via the bench, then one trigger) -> pulse_count wraps to 0.

Source files
------------

// File: rtl/sonar_echo_emulator.sv
// HC-SR04-style ultrasonic sensor emulator: qualifies a trigger pulse, waits out the
// burst time, then answers with an echo pulse of programmable width followed by a dead time.
module sonar_echo_emulator #(
  parameter int unsigned MIN_TRIG_CYCLES = 32'd500,
  parameter int unsigned BURST_CYCLES    = 32'd10000,
  parameter int unsigned MAX_ECHO_CYCLES = 32'd1900000,
  parameter int unsigned HOLDOFF_CYCLES  = 32'd500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic [31:0] echo_width,
  output logic        echo,
  output logic        busy,
  output logic        trig_err,
  output logic        trig_ignored,
  output logic [15:0] pulse_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG_HIGH,
    ST_BURST,
    ST_ECHO,
    ST_HOLDOFF
  } state_t;

  state_t      state_r;
  logic        sync_meta_r;
  logic        trig_s_r;
  logic        trig_prev_r;
  logic [2:0]  vld_r;
  logic        rise_s;
  logic [31:0] tcnt_r;
  logic [31:0] cnt_r;
  logic [31:0] width_r;

  // Zero means "no object" and maps to the full timeout pulse; larger requests clip to the cap.
  function automatic logic [31:0] cap_width(input logic [31:0] req);
    if (req == 32'd0) begin
      return MAX_ECHO_CYCLES;
    end else if (req > MAX_ECHO_CYCLES) begin
      return MAX_ECHO_CYCLES;
    end else begin
      return req;
    end
  endfunction

  // Two-flop synchronizer, previous-sample register and a validity pipeline for both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta_r <= 1'b0;
      trig_s_r    <= 1'b0;
      trig_prev_r <= 1'b0;
      vld_r       <= 3'b000;
    end else begin
      sync_meta_r <= trigger;
      trig_s_r    <= sync_meta_r;
      trig_prev_r <= trig_s_r;
      vld_r       <= {vld_r[1:0], 1'b1};
    end
  end

  // An edge only counts once the previous sample holds a real pin value, so a trigger
  // already high when reset releases is seen as a level, not a rising edge.
  assign rise_s = trig_s_r & ~trig_prev_r & vld_r[2];

  // Main sequencer with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      tcnt_r       <= 32'd0;
      cnt_r        <= 32'd0;
      width_r      <= 32'd0;
      echo         <= 1'b0;
      busy         <= 1'b0;
      trig_err     <= 1'b0;
      trig_ignored <= 1'b0;
      pulse_count  <= 16'd0;
    end else begin
      trig_err     <= 1'b0;
      trig_ignored <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (rise_s) begin
            state_r <= ST_TRIG_HIGH;
            tcnt_r  <= 32'd1;
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end
        ST_TRIG_HIGH: begin
          if (trig_s_r) begin
            if (tcnt_r < MIN_TRIG_CYCLES) begin
              tcnt_r <= tcnt_r + 32'd1;
            end else begin
              tcnt_r <= tcnt_r;
            end
          end else if (tcnt_r >= MIN_TRIG_CYCLES) begin
            width_r <= cap_width(echo_width);
            cnt_r   <= 32'd0;
            state_r <= ST_BURST;
          end else begin
            trig_err <= 1'b1;
            busy     <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        ST_BURST: begin
          trig_ignored <= rise_s;
          if (cnt_r >= BURST_CYCLES - 32'd1) begin
            cnt_r   <= 32'd0;
            echo    <= 1'b1;
            state_r <= ST_ECHO;
          end else begin
            cnt_r   <= cnt_r + 32'd1;
          end
        end
        ST_ECHO: begin
          trig_ignored <= rise_s;
          if (cnt_r + 32'd1 >= width_r) begin
            cnt_r       <= 32'd0;
            echo        <= 1'b0;
            pulse_count <= pulse_count + 16'd1;
            state_r     <= ST_HOLDOFF;
          end else begin
            cnt_r       <= cnt_r + 32'd1;
          end
        end
        ST_HOLDOFF: begin
          trig_ignored <= rise_s;
          if (cnt_r >= HOLDOFF_CYCLES - 32'd1) begin
            cnt_r   <= 32'd0;
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r   <= cnt_r + 32'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 32'd0;
          echo    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sonar_echo_emulator.sv
// Directed bench for sonar_echo_emulator with small timing parameters
// (MIN_TRIG=5, BURST=8, MAX_ECHO=100, HOLDOFF=20).
module tb_sonar_echo_emulator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        trigger = 1'b0;
  logic [31:0] echo_width = 32'd0;
  logic        echo;
  logic        busy;
  logic        trig_err;
  logic        trig_ignored;
  logic [15:0] pulse_count;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  int ign_tot = 0;
  int err_tot = 0;
  int hi_tot = 0;
  int rise_tot = 0;
  int busy_tot = 0;
  logic echo_prev = 1'b0;

  sonar_echo_emulator #(
    .MIN_TRIG_CYCLES(32'd5),
    .BURST_CYCLES(32'd8),
    .MAX_ECHO_CYCLES(32'd100),
    .HOLDOFF_CYCLES(32'd20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .trigger(trigger),
    .echo_width(echo_width),
    .echo(echo),
    .busy(busy),
    .trig_err(trig_err),
    .trig_ignored(trig_ignored),
    .pulse_count(pulse_count)
  );

  always #5 clk = ~clk;

  // Running totals of output activity, sampled mid-cycle.
  always @(negedge clk) begin
    ign_tot   <= ign_tot + int'(trig_ignored);
    err_tot   <= err_tot + int'(trig_err);
    hi_tot    <= hi_tot + int'(echo);
    busy_tot  <= busy_tot + int'(busy);
    rise_tot  <= rise_tot + int'(echo & ~echo_prev);
    echo_prev <= echo;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_trigger(input int n);
    trigger = 1'b1;
    repeat (n) tick();
    trigger = 1'b0;
  endtask

  task automatic wait_echo(input logic val, output int n);
    n = 0;
    while (echo !== val && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
  endtask

  // Full measurement: echo rises 11 samples after the pin falls (2 sync + 9).
  task automatic run_echo(input string tag, input int n, input int exp_w);
    int lat;
    int w;
    int h;
    pulse_trigger(n);
    wait_echo(1'b1, lat);
    check({tag, "_latency"}, lat, 32'd11);
    w = 0;
    while (echo === 1'b1 && w < 300) begin
      w++;
      tick();
    end
    check({tag, "_width"}, w, exp_w);
    h = 0;
    while (busy === 1'b1 && h < 300) begin
      h++;
      tick();
    end
    check({tag, "_holdoff"}, h, 32'd20);
  endtask

  // Too-short trigger: trig_err pulses once, 3 samples after the pin falls.
  task automatic short_trigger(input string tag, input int n);
    int s_err;
    int s_rise;
    s_err  = err_tot;
    s_rise = rise_tot;
    pulse_trigger(n);
    repeat (3) tick();
    check({tag, "_err_hi"}, trig_err, 32'd1);
    tick();
    check({tag, "_err_lo"}, trig_err, 32'd0);
    check({tag, "_busy"}, busy, 32'd0);
    repeat (20) tick();
    check({tag, "_err_count"}, err_tot - s_err, 32'd1);
    check({tag, "_no_echo"}, rise_tot - s_rise, 32'd0);
  endtask

  initial begin
    int n;
    int s_ign;
    int s_rise;
    int s_hi;
    int s_busy;
    int s_err;

    repeat (3) tick();
    check("rst_echo", echo, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_trig_err", trig_err, 32'd0);
    check("rst_trig_ignored", trig_ignored, 32'd0);
    check("rst_pulse_count", pulse_count, 32'd0);
    reset = 1'b1;
    repeat (3) tick();

    // 1: nominal echo of 37 cycles
    echo_width = 32'd37;
    run_echo("t1", 10, 37);
    check("t1_pc", pulse_count, 32'd1);

    // 2: short triggers, including the one-below-minimum boundary
    short_trigger("t2_len3", 3);
    short_trigger("t2_len4", 4);
    check("t2_pc", pulse_count, 32'd1);

    // exactly the minimum width is accepted
    echo_width = 32'd2;
    run_echo("t2_len5", 5, 2);
    check("t2_len5_pc", pulse_count, 32'd2);

    // 3: zero width -> timeout pulse; oversize request clipped, late change ignored
    echo_width = 32'd0;
    run_echo("t3_zero", 10, 100);
    check("t3_zero_pc", pulse_count, 32'd3);
    s_hi = hi_tot;
    echo_width = 32'd500;
    pulse_trigger(10);
    wait_echo(1'b1, n);
    check("t3_big_latency", n, 32'd11);
    echo_width = 32'd3;
    wait_idle(n);
    tick();
    check("t3_big_width", hi_tot - s_hi, 32'd100);
    check("t3_big_pc", pulse_count, 32'd4);

    // 4: triggers during ECHO and HOLDOFF are flagged and ignored
    echo_width = 32'd37;
    s_ign  = ign_tot;
    s_rise = rise_tot;
    s_hi   = hi_tot;
    pulse_trigger(10);
    wait_echo(1'b1, n);
    repeat (5) tick();
    pulse_trigger(10);
    wait_echo(1'b0, n);
    repeat (3) tick();
    pulse_trigger(10);
    wait_idle(n);
    tick();
    check("t4_ignored", ign_tot - s_ign, 32'd2);
    check("t4_rises", rise_tot - s_rise, 32'd1);
    check("t4_width", hi_tot - s_hi, 32'd37);
    check("t4_pc", pulse_count, 32'd5);
    echo_width = 32'd12;
    run_echo("t4_after", 10, 12);
    check("t4_after_pc", pulse_count, 32'd6);

    // 5: reset mid-echo, trigger held across release
    echo_width = 32'd37;
    pulse_trigger(10);
    wait_echo(1'b1, n);
    repeat (14) tick();
    check("t5_echo_before", echo, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_echo_in_reset", echo, 32'd0);
    check("t5_pc_in_reset", pulse_count, 32'd0);
    check("t5_busy_in_reset", busy, 32'd0);
    trigger = 1'b1;
    tick();
    tick();
    s_busy = busy_tot;
    s_err  = err_tot;
    s_rise = rise_tot;
    reset = 1'b1;
    repeat (10) tick();
    trigger = 1'b0;
    repeat (15) tick();
    check("t5_held_busy", busy_tot - s_busy, 32'd0);
    check("t5_held_err", err_tot - s_err, 32'd0);
    check("t5_held_rise", rise_tot - s_rise, 32'd0);
    echo_width = 32'd20;
    run_echo("t5_clean", 10, 20);
    check("t5_clean_pc", pulse_count, 32'd1);

    // 6: pulse_count wrap with a minimal echo
    force dut.pulse_count = 16'hffff;
    tick();
    release dut.pulse_count;
    tick();
    check("t6_preset", pulse_count, 32'd65535);
    echo_width = 32'd1;
    run_echo("t6", 10, 1);
    check("t6_wrap", pulse_count, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
